// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: bubble PC,
// stage occupancy states and the payload layouts of each stage boundary.
package pipe_pkg;

    localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    // F/D boundary
    localparam int FD_INSTR_W   = 32;
    localparam int FD_PAYLOAD_W = FD_INSTR_W;

    // D/E boundary
    localparam int DE_INSTR_W   = 32;
    localparam int DE_RD1_W     = 32;
    localparam int DE_RD2_W     = 32;
    localparam int DE_EXT_W     = 32;
    localparam int DE_A3_W      = 5;
    localparam int DE_PAYLOAD_W = DE_INSTR_W + DE_RD1_W + DE_RD2_W + DE_EXT_W + DE_A3_W;

    // E/M boundary
    localparam int EM_INSTR_W   = 32;
    localparam int EM_A3_W      = 5;
    localparam int EM_WD_W      = 32;
    localparam int EM_ALU_W     = 32;
    localparam int EM_RD2_W     = 32;
    localparam int EM_PAYLOAD_W = EM_INSTR_W + EM_A3_W + EM_WD_W + EM_ALU_W + EM_RD2_W;

    // M/W boundary
    localparam int MW_INSTR_W   = 32;
    localparam int MW_A3_W      = 5;
    localparam int MW_WD_W      = 32;
    localparam int MW_ALU_W     = 32;
    localparam int MW_DM_W      = 32;
    localparam int MW_PAYLOAD_W = MW_INSTR_W + MW_A3_W + MW_WD_W + MW_ALU_W + MW_DM_W;

    function automatic logic [1:0] state_occupancy(input stage_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One PC + payload entry of a pipeline stage; clearing turns it into a bubble
// (default PC, all-zero payload) so stale data never leaks downstream.
module pipe_entry_reg #(
    parameter int              PC_W      = 32,
    parameter int              PAYLOAD_W = 128,
    parameter logic [PC_W-1:0] BUBBLE_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [PC_W-1:0]      d_pc,
    input  logic [PAYLOAD_W-1:0] d_payload,
    output logic [PC_W-1:0]      q_pc,
    output logic [PAYLOAD_W-1:0] q_payload
);
    import pipe_pkg::*;

    // Clear beats load so a kill in the same cycle as a refill wins.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_pc      <= BUBBLE_PC;
            q_payload <= '0;
        end else if (load) begin
            q_pc      <= d_pc;
            q_payload <= d_payload;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int              PC_W       = 32,
    parameter int              PAYLOAD_W  = 128,
    parameter logic [PC_W-1:0] PC_DEFAULT = PC_W'(32'h0000_3000),
    parameter bit              SKID_EN    = 1'b1,
    parameter int              CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);
    import pipe_pkg::*;

    stage_state_t state_q, state_d;

    logic accept, consume;
    logic main_load, main_clear, main_src_skid;
    logic skid_load, skid_clear;
    logic [PC_W-1:0]      main_d_pc, skid_pc;
    logic [PAYLOAD_W-1:0] main_d_payload, skid_payload;

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_occupancy(state_q);

    // With the skid buffer, in_ready depends only on state so out_ready never
    // reaches upstream combinationally.
    assign in_ready = SKID_EN ? (state_q != ST_TWO) : (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_src_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept && SKID_EN) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (consume) begin
                        main_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_load     = 1'b1;
                        main_src_skid = 1'b1;
                        skid_clear    = 1'b1;
                        state_d       = ST_ONE;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = ST_EMPTY;
                end
            endcase
        end
    end

    assign main_d_pc      = main_src_skid ? skid_pc      : in_pc;
    assign main_d_payload = main_src_skid ? skid_payload : in_payload;

    pipe_entry_reg #(
        .PC_W      (PC_W),
        .PAYLOAD_W (PAYLOAD_W),
        .BUBBLE_PC (PC_DEFAULT)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .load      (main_load),
        .clear     (main_clear),
        .d_pc      (main_d_pc),
        .d_payload (main_d_payload),
        .q_pc      (out_pc),
        .q_payload (out_payload)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_entry_reg #(
                .PC_W      (PC_W),
                .PAYLOAD_W (PAYLOAD_W),
                .BUBBLE_PC (PC_DEFAULT)
            ) u_skid (
                .clk       (clk),
                .reset     (reset),
                .load      (skid_load),
                .clear     (skid_clear),
                .d_pc      (in_pc),
                .d_payload (in_payload),
                .q_pc      (skid_pc),
                .q_payload (skid_payload)
            );
        end else begin : g_no_skid
            logic skid_ctrl_unused;
            assign skid_ctrl_unused = skid_load | skid_clear;
            assign skid_pc          = PC_DEFAULT;
            assign skid_payload     = '0;
        end
    endgenerate

    // Counts every cycle the stage presents data that downstream refuses;
    // flush leaves the count alone so stall statistics survive branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid-buffered instance with a 4-bit
// stall counter and a single-entry instance, checked against hand-derived values.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic reset;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_pc, a_out_pc;
    logic [63:0] a_in_payload, a_out_payload;
    logic [1:0]  a_occ;
    logic [3:0]  a_stall;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_pc, b_out_pc;
    logic [63:0] b_in_payload, b_out_payload;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .PC_W(32), .PAYLOAD_W(64), .PC_DEFAULT(32'h0000_3000), .SKID_EN(1'b1), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_payload(a_in_payload),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_payload(a_out_payload),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_skid #(
        .PC_W(32), .PAYLOAD_W(64), .PC_DEFAULT(32'h0000_3000), .SKID_EN(1'b0), .CNT_W(16)
    ) dut_noskid (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_payload(b_in_payload),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_payload(b_out_payload),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    function automatic logic [63:0] pl(input logic [31:0] pc);
        return {~pc, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic v, input logic [31:0] pc);
        a_in_valid   = v;
        a_in_pc      = pc;
        a_in_payload = pl(pc);
    endtask

    task automatic offer_b(input logic v, input logic [31:0] pc);
        b_in_valid   = v;
        b_in_pc      = pc;
        b_in_payload = pl(pc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_flush = 1'b0; a_out_ready = 1'b0; offer_a(1'b0, 32'h0);
        b_flush = 1'b0; b_out_ready = 1'b0; offer_b(1'b0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({a_out_valid, a_out_pc, a_occ, a_in_ready} !== {1'b0, 32'h3000, 2'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got valid=%b pc=%h occ=%0d rdy=%b, expected valid=0 pc=00003000 occ=0 rdy=1",
                     a_out_valid, a_out_pc, a_occ, a_in_ready);
        end
        vectors++;
        if ({a_out_payload, a_stall} !== {64'h0, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_payload_cnt: got payload=%h stall=%0d, expected 0 and 0", a_out_payload, a_stall);
        end
        vectors++;
        if ({b_out_valid, b_out_pc, b_occ, b_in_ready} !== {1'b0, 32'h3000, 2'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_noskid: got valid=%b pc=%h occ=%0d rdy=%b, expected valid=0 pc=00003000 occ=0 rdy=1",
                     b_out_valid, b_out_pc, b_occ, b_in_ready);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] pc;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            offer_a(1'b1, pc);
            tick();
            vectors++;
            if ({a_out_valid, a_out_pc, a_out_payload, a_occ} !== {1'b1, pc, pl(pc), 2'd1}) begin
                miscompares++;
                $display("[TB] FAIL stream_%0d: got valid=%b pc=%h payload=%h occ=%0d, expected valid=1 pc=%h payload=%h occ=1",
                         i, a_out_valid, a_out_pc, a_out_payload, a_occ, pc, pl(pc));
            end
        end
        offer_a(1'b0, 32'h0);
        tick();
        vectors++;
        if ({a_out_valid, a_out_pc, a_out_payload, a_stall} !== {1'b0, 32'h3000, 64'h0, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL stream_drain: got valid=%b pc=%h payload=%h stall=%0d, expected valid=0 pc=00003000 payload=0 stall=0",
                     a_out_valid, a_out_pc, a_out_payload, a_stall);
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b1;
        offer_a(1'b1, 32'h3010);
        tick();
        a_out_ready = 1'b0;
        offer_a(1'b1, 32'h3014);
        tick();
        vectors++;
        if ({a_occ, a_in_ready, a_out_pc} !== {2'd2, 1'b0, 32'h3010}) begin
            miscompares++;
            $display("[TB] FAIL skid_fill: got occ=%0d rdy=%b pc=%h, expected occ=2 rdy=0 pc=00003010", a_occ, a_in_ready, a_out_pc);
        end
        offer_a(1'b1, 32'h3018);
        tick();
        vectors++;
        if ({a_occ, a_out_pc, a_out_payload} !== {2'd2, 32'h3010, pl(32'h3010)}) begin
            miscompares++;
            $display("[TB] FAIL skid_hold: got occ=%0d pc=%h payload=%h, expected occ=2 pc=00003010 payload=%h",
                     a_occ, a_out_pc, a_out_payload, pl(32'h3010));
        end
        offer_a(1'b0, 32'h0);
        a_out_ready = 1'b1;
        tick();
        vectors++;
        if ({a_out_valid, a_occ, a_in_ready, a_out_pc, a_out_payload} !== {1'b1, 2'd1, 1'b1, 32'h3014, pl(32'h3014)}) begin
            miscompares++;
            $display("[TB] FAIL skid_drain: got valid=%b occ=%0d rdy=%b pc=%h payload=%h, expected valid=1 occ=1 rdy=1 pc=00003014 payload=%h",
                     a_out_valid, a_occ, a_in_ready, a_out_pc, a_out_payload, pl(32'h3014));
        end
        tick();
        vectors++;
        if ({a_out_valid, a_occ, a_stall} !== {1'b0, 2'd0, 4'd2}) begin
            miscompares++;
            $display("[TB] FAIL skid_empty: got valid=%b occ=%0d stall=%0d, expected valid=0 occ=0 stall=2", a_out_valid, a_occ, a_stall);
        end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        offer_a(1'b1, 32'h3018);
        tick();
        offer_a(1'b1, 32'h301C);
        tick();
        vectors++;
        if ({a_occ, a_stall} !== {2'd2, 4'd3}) begin
            miscompares++;
            $display("[TB] FAIL flush_setup: got occ=%0d stall=%0d, expected occ=2 stall=3", a_occ, a_stall);
        end
        a_flush = 1'b1;
        a_out_ready = 1'b1;
        offer_a(1'b1, 32'h3020);
        tick();
        a_flush = 1'b0;
        offer_a(1'b0, 32'h0);
        vectors++;
        if ({a_out_valid, a_out_pc, a_out_payload, a_occ, a_stall, a_in_ready} !== {1'b0, 32'h3000, 64'h0, 2'd0, 4'd3, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL flush_two: got valid=%b pc=%h payload=%h occ=%0d stall=%0d rdy=%b, expected valid=0 pc=00003000 payload=0 occ=0 stall=3 rdy=1",
                     a_out_valid, a_out_pc, a_out_payload, a_occ, a_stall, a_in_ready);
        end
        tick();
        vectors++;
        if ({a_out_valid, a_out_pc} !== {1'b0, 32'h3000}) begin
            miscompares++;
            $display("[TB] FAIL flush_no_revival: got valid=%b pc=%h, expected valid=0 pc=00003000", a_out_valid, a_out_pc);
        end
        a_flush = 1'b1;
        offer_a(1'b1, 32'h3024);
        #1;
        vectors++;
        if (a_in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_empty_ready: got rdy=%b, expected rdy=1", a_in_ready);
        end
        tick();
        a_flush = 1'b0;
        offer_a(1'b0, 32'h0);
        vectors++;
        if ({a_out_valid, a_out_pc, a_occ} !== {1'b0, 32'h3000, 2'd0}) begin
            miscompares++;
            $display("[TB] FAIL flush_drop: got valid=%b pc=%h occ=%0d, expected valid=0 pc=00003000 occ=0", a_out_valid, a_out_pc, a_occ);
        end
    endtask

    task automatic test_saturation();
        a_out_ready = 1'b0;
        offer_a(1'b1, 32'h3030);
        tick();
        offer_a(1'b0, 32'h0);
        repeat (5) tick();
        vectors++;
        if (a_stall !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL stall_count: got %0d, expected 8", a_stall);
        end
        repeat (15) tick();
        vectors++;
        if ({a_stall, a_out_pc, a_occ} !== {4'd15, 32'h3030, 2'd1}) begin
            miscompares++;
            $display("[TB] FAIL stall_saturate: got stall=%0d pc=%h occ=%0d, expected stall=15 pc=00003030 occ=1", a_stall, a_out_pc, a_occ);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({a_stall, a_out_valid, a_occ, a_out_pc, a_out_payload} !== {4'd0, 1'b0, 2'd0, 32'h3000, 64'h0}) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: got stall=%0d valid=%b occ=%0d pc=%h payload=%h, expected 0 0 0 00003000 0",
                     a_stall, a_out_valid, a_occ, a_out_pc, a_out_payload);
        end
    endtask

    task automatic test_no_skid();
        b_out_ready = 1'b0;
        offer_b(1'b1, 32'h3040);
        #1;
        vectors++;
        if (b_in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL noskid_empty_ready: got rdy=%b, expected 1", b_in_ready);
        end
        tick();
        vectors++;
        if ({b_out_valid, b_out_pc, b_occ, b_in_ready} !== {1'b1, 32'h3040, 2'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL noskid_hold: got valid=%b pc=%h occ=%0d rdy=%b, expected valid=1 pc=00003040 occ=1 rdy=0",
                     b_out_valid, b_out_pc, b_occ, b_in_ready);
        end
        offer_b(1'b1, 32'h3044);
        tick();
        vectors++;
        if ({b_out_pc, b_occ} !== {32'h3040, 2'd1}) begin
            miscompares++;
            $display("[TB] FAIL noskid_blocked: got pc=%h occ=%0d, expected pc=00003040 occ=1", b_out_pc, b_occ);
        end
        b_out_ready = 1'b1;
        #1;
        vectors++;
        if (b_in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL noskid_comb_ready: got rdy=%b, expected 1", b_in_ready);
        end
        tick();
        vectors++;
        if ({b_out_valid, b_out_pc, b_out_payload, b_occ} !== {1'b1, 32'h3044, pl(32'h3044), 2'd1}) begin
            miscompares++;
            $display("[TB] FAIL noskid_replace: got valid=%b pc=%h payload=%h occ=%0d, expected valid=1 pc=00003044 payload=%h occ=1",
                     b_out_valid, b_out_pc, b_out_payload, b_occ, pl(32'h3044));
        end
        b_out_ready = 1'b0;
        #1;
        vectors++;
        if (b_in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL noskid_comb_stall: got rdy=%b, expected 0", b_in_ready);
        end
        offer_b(1'b0, 32'h0);
        b_out_ready = 1'b1;
        tick();
        vectors++;
        if ({b_out_valid, b_out_pc, b_out_payload, b_stall} !== {1'b0, 32'h3000, 64'h0, 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL noskid_drain: got valid=%b pc=%h payload=%h stall=%0d, expected valid=0 pc=00003000 payload=0 stall=1",
                     b_out_valid, b_out_pc, b_out_payload, b_stall);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_no_skid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
